// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2
   } state_t;

   localparam logic [1:0] BYTE_0 = 2'd0;
   localparam logic [1:0] BYTE_1 = 2'd1;
   localparam logic [1:0] BYTE_2 = 2'd2;
   localparam logic [1:0] BYTE_3 = 2'd3;

   function automatic int gate_div(input logic [1:0] sel);
      case (sel)
         2'd0:    return 1;
         2'd1:    return 10;
         2'd2:    return 100;
         default: return 1000;
      endcase
   endfunction

endpackage

// File: rtl/freq_meter_edge_det.sv
// Synchronizer and rising-edge detector for sig_in.
// FREQ_METER_DEGLITCH_EN adds a two-sample agreement filter (4 clk latency).
module freq_meter_edge_det
   import freq_meter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic edge_pulse
);

   logic sync1, sync2;

`ifdef FREQ_METER_DEGLITCH_EN
   logic sync3, filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         filt  <= 1'b0;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
         sync3 <= sync2;
         if (sync2 == sync3) filt <= sync2;
      end
   end

   // pulse in the cycle the filter is about to rise
   assign edge_pulse = sync2 & sync3 & ~filt;
`else
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign edge_pulse = sync2 & ~prev;
`endif

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over a gate of clk cycles.
// Optional input deglitch filter via FREQ_METER_DEGLITCH_EN (see freq_meter_edge_det).
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ      = 60000000,
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int CNT_W       = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [1:0]       gate_sel,
   input  logic             sig_in,
   input  logic [1:0]       byte_sel,
   output logic [CNT_W-1:0] freq_cnt,
   output logic             valid,
   output logic             ovf,
   output logic             busy,
   output logic [7:0]       data_out
);

   localparam int GW = $clog2(GATE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [GW-1:0] LEN0 = GW'(GATE_CYCLES / gate_div(2'd0));
   localparam logic [GW-1:0] LEN1 = GW'(GATE_CYCLES / gate_div(2'd1));
   localparam logic [GW-1:0] LEN2 = GW'(GATE_CYCLES / gate_div(2'd2));
   localparam logic [GW-1:0] LEN3 = GW'(GATE_CYCLES / gate_div(2'd3));

   state_t           state, state_next;
   logic [GW-1:0]    gate_cnt, gate_len, len_sel;
   logic [CNT_W-1:0] edge_cnt, edge_cnt_next;
   logic             ovf_int, ovf_int_next;
   logic             edge_pulse, arm, capture, last;
   logic [31:0]      word;

   freq_meter_edge_det u_edge_det (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .edge_pulse (edge_pulse)
   );

   always_comb begin
      case (gate_sel)
         2'd0:    len_sel = LEN0;
         2'd1:    len_sel = LEN1;
         2'd2:    len_sel = LEN2;
         default: len_sel = LEN3;
      endcase
   end

   assign last = (gate_cnt == gate_len - GW'(1));

   // saturating edge count; an increment attempted at full scale flags overflow
   always_comb begin
      edge_cnt_next = edge_cnt;
      ovf_int_next  = ovf_int;
      if (edge_pulse) begin
         if (edge_cnt == CNT_MAX) ovf_int_next  = 1'b1;
         else                     edge_cnt_next = edge_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      arm        = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: if (run) state_next = ARM;
         ARM: begin
            arm        = 1'b1;
            state_next = run ? GATE : IDLE;
         end
         GATE: begin
            if (!run) begin
               state_next = IDLE;
            end else if (last) begin
               capture    = 1'b1;
               state_next = ARM;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt <= '0;
         gate_len <= '0;
         edge_cnt <= '0;
         ovf_int  <= 1'b0;
         freq_cnt <= '0;
         ovf      <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= capture;
         if (arm) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
            gate_len <= len_sel;
         end else if (state == GATE) begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_cnt_next;
            ovf_int  <= ovf_int_next;
         end
         if (capture) begin
            freq_cnt <= edge_cnt_next;
            ovf      <= ovf_int_next;
         end
      end
   end

   assign busy = (state != IDLE);

   always_comb begin
      word            = '0;
      word[CNT_W-1:0] = freq_cnt;
      word[31]        = ovf;
   end

   always_comb begin
      case (byte_sel)
         BYTE_0:  data_out = word[7:0];
         BYTE_1:  data_out = word[15:8];
         BYTE_2:  data_out = word[23:16];
         default: data_out = word[31:24];
      endcase
   end

endmodule
